// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Memory-side responder for the CPU data SRAM port. Byte-lane writes
//   commit in one cycle; reads return registered data after 1+WAIT_CYCLES
//   edges, with o_stallreq holding the requester while wait states elapse.
//
//   State table:
//     S_IDLE | accepting requests; writes commit, zero-wait reads complete
//     S_WAIT | read latched, counting down wait states before returning data
//
// Ports:
//   clk                 clock, all updates on posedge
//   rst                 synchronous active-high reset
//   i_data_sram_en      access request this cycle
//   i_data_sram_wen     byte write enables (zero = read)
//   i_data_sram_addr    byte address, bits [1:0] ignored
//   i_data_sram_wdata   write data, lane i = bits [8i+7:8i]
//   o_data_sram_rdata   registered read data
//   o_stallreq          combinational hold request to the pipeline
//   o_range_err         registered one-cycle pulse on out-of-range access
module data_sram_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_data_sram_en,
  input  logic [3:0]  i_data_sram_wen,
  input  logic [31:0] i_data_sram_addr,
  input  logic [31:0] i_data_sram_wdata,
  output logic [31:0] o_data_sram_rdata,
  output logic        o_stallreq,
  output logic        o_range_err
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [31:0]          r_mem [DEPTH];
  logic [31:0]          r_rdata;
  logic                 r_range_err, w_range_err_nxt;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic [ADDR_BITS-1:0] r_idx, w_idx, w_rd_idx;
  logic                 r_oor, w_oor, w_rd_oor;
  logic                 w_acc_rd, w_acc_wr, w_rd_fire;
  logic                 w_unused_addr_lsb;

  assign w_idx             = i_data_sram_addr[ADDR_BITS+1:2];
  assign w_oor             = |i_data_sram_addr[31:ADDR_BITS+2];
  assign w_unused_addr_lsb = ^i_data_sram_addr[1:0];
  assign w_acc_rd          = i_data_sram_en && (i_data_sram_wen == 4'd0);
  assign w_acc_wr          = i_data_sram_en && (i_data_sram_wen != 4'd0) && (r_state == S_IDLE);

  assign o_data_sram_rdata = r_rdata;
  assign o_range_err       = r_range_err;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    o_stallreq      = 1'b0;
    w_rd_fire       = 1'b0;
    w_rd_idx        = w_idx;
    w_rd_oor        = w_oor;
    w_range_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc_rd) begin
          if (WAIT_CYCLES == 0) begin
            w_rd_fire       = 1'b1;
            w_range_err_nxt = w_oor;
          end else begin
            // range error is reported when the data returns, not at accept
            o_stallreq  = 1'b1;
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end else if (w_acc_wr) begin
          w_range_err_nxt = w_oor;
        end
      end
      S_WAIT: begin
        // live inputs are ignored here; the latched request is served
        w_rd_idx = r_idx;
        w_rd_oor = r_oor;
        if (r_cnt != 4'd0) begin
          o_stallreq = 1'b1;
          w_cnt_nxt  = r_cnt - 4'd1;
        end else begin
          w_rd_fire       = 1'b1;
          w_range_err_nxt = r_oor;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_oor       <= 1'b0;
      r_rdata     <= 32'd0;
      r_range_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_range_err <= w_range_err_nxt;
      if ((r_state == S_IDLE) && w_acc_rd) begin
        r_idx <= w_idx;
        r_oor <= w_oor;
      end
      if (w_rd_fire) begin
        r_rdata <= w_rd_oor ? 32'd0 : r_mem[w_rd_idx];
      end
    end
  end

  // Memory is not reset; disabled lanes keep their current contents.
  always_ff @(posedge clk) begin
    if (!rst && w_acc_wr && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (i_data_sram_wen[i]) begin
          r_mem[w_idx][8*i +: 8] <= i_data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic        en0, en3;
  logic [3:0]  wen0, wen3;
  logic [31:0] addr0, addr3, wdata0, wdata3;
  logic [31:0] rdata0, rdata3;
  logic        stall0, stall3, rerr0, rerr3;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst0),
    .i_data_sram_en(en0), .i_data_sram_wen(wen0),
    .i_data_sram_addr(addr0), .i_data_sram_wdata(wdata0),
    .o_data_sram_rdata(rdata0), .o_stallreq(stall0), .o_range_err(rerr0)
  );

  data_sram_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .i_data_sram_en(en3), .i_data_sram_wen(wen3),
    .i_data_sram_addr(addr3), .i_data_sram_wdata(wdata3),
    .o_data_sram_rdata(rdata3), .o_stallreq(stall3), .o_range_err(rerr3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m0 [1024];
  logic [31:0] m3 [1024];
  logic [31:0] q0 [$];
  logic [31:0] q3 [$];
  logic [31:0] exp_rd0 = 32'd0;
  logic [31:0] exp_rd3 = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // one IDLE-state access on the zero-wait instance; called just after a negedge
  task automatic step0(input string tag, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic oor;
    logic exp_re;
    logic [31:0] got;
    oor = |addr[31:12];
    exp_re = en && oor;
    en0 = en; wen0 = wen; addr0 = addr; wdata0 = wd;
    if (en && wen != 4'd0 && !oor) m0[addr[11:2]] = merge(m0[addr[11:2]], wd, wen);
    if (en && wen == 4'd0) q0.push_back(oor ? 32'd0 : m0[addr[11:2]]);
    #1 check({tag, "_stall"}, {31'd0, stall0}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_rerr"}, {31'd0, rerr0}, {31'd0, exp_re});
    if (en && wen == 4'd0) begin
      got = q0.pop_front();
      exp_rd0 = got;
    end
    check({tag, "_rdata"}, rdata0, exp_rd0);
    @(negedge clk);
  endtask

  task automatic write3(input logic [31:0] addr, input logic [31:0] wd);
    en3 = 1'b1; wen3 = 4'hF; addr3 = addr; wdata3 = wd;
    if (!(|addr[31:12])) m3[addr[11:2]] = wd;
    #1 check("w3_stall", {31'd0, stall3}, 32'd0);
    @(posedge clk); #1;
    check("w3_rdata_hold", rdata3, exp_rd3);
    @(negedge clk);
    en3 = 1'b0;
  endtask

  // read on the 3-wait instance; optionally scrambles inputs while stalled
  task automatic read3(input string tag, input logic [31:0] addr, input bit scramble);
    logic oor;
    oor = |addr[31:12];
    en3 = 1'b1; wen3 = 4'h0; addr3 = addr; wdata3 = 32'h0;
    q3.push_back(oor ? 32'd0 : m3[addr[11:2]]);
    for (int k = 0; k < 3; k++) begin
      #1 check({tag, "_stall_hi"}, {31'd0, stall3}, 32'd1);
      @(posedge clk); #1;
      check({tag, "_wait_rerr"}, {31'd0, rerr3}, 32'd0);
      check({tag, "_wait_rdata"}, rdata3, exp_rd3);
      @(negedge clk);
      if (scramble) begin
        addr3 = addr ^ 32'h0000_0024; wen3 = 4'hF; wdata3 = 32'hBAD0_BAD0;
      end
    end
    #1 check({tag, "_stall_lo"}, {31'd0, stall3}, 32'd0);
    @(posedge clk); #1;
    exp_rd3 = q3.pop_front();
    check({tag, "_rdata"}, rdata3, exp_rd3);
    check({tag, "_rerr"}, {31'd0, rerr3}, {31'd0, oor});
    @(negedge clk);
    en3 = 1'b0; wen3 = 4'h0;
    #1 check({tag, "_after_stall"}, {31'd0, stall3}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_after_rerr"}, {31'd0, rerr3}, 32'd0);
    check({tag, "_after_rdata"}, rdata3, exp_rd3);
    @(negedge clk);
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    en0 = 1'b0; wen0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
    en3 = 1'b0; wen3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;

    // reset held two cycles, then idle
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata3", rdata3, 32'd0);
      check("rst_stall0", {31'd0, stall0}, 32'd0);
      check("rst_stall3", {31'd0, stall3}, 32'd0);
      check("rst_rerr0", {31'd0, rerr0}, 32'd0);
      check("rst_rerr3", {31'd0, rerr3}, 32'd0);
      if (c == 1) begin rst0 = 1'b0; rst3 = 1'b0; end
    end
    @(negedge clk);
    step0("idle", 1'b0, 4'h0, 32'h0, 32'h0);

    // full write then read
    step0("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step0("rd10", 1'b1, 4'h0, 32'h10, 32'h0);
    check("rd10_const", rdata0, 32'hDEADBEEF);

    // byte-lane merge, aliased address
    step0("wr20", 1'b1, 4'hF, 32'h20, 32'h11223344);
    step0("wr20p", 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    step0("rd23", 1'b1, 4'h0, 32'h23, 32'h0);
    check("rd23_const", rdata0, 32'h11BB33DD);

    // out-of-range read and write
    step0("wr0", 1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
    step0("oor_rd", 1'b1, 4'h0, 32'h1000, 32'h0);
    step0("oor_idle", 1'b0, 4'h0, 32'h1000, 32'h0);
    step0("oor_wr", 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF);
    step0("rd0", 1'b1, 4'h0, 32'h0, 32'h0);
    check("rd0_const", rdata0, 32'hCAFEF00D);

    // back-to-back reads
    step0("b2b_a", 1'b1, 4'h0, 32'h10, 32'h0);
    step0("b2b_b", 1'b1, 4'h0, 32'h20, 32'h0);
    step0("b2b_c", 1'b1, 4'h0, 32'h4, 32'h0);
    step0("b2b_d", 1'b1, 4'h0, 32'h1004, 32'h0);
    step0("b2b_idle", 1'b0, 4'h0, 32'h0, 32'h0);

    // wait states
    write3(32'h10, 32'h12345678);
    write3(32'h34, 32'h55AA55AA);
    read3("w3rd10", 32'h10, 1'b1);
    read3("w3oor", 32'h1000, 1'b0);
    read3("w3rd34", 32'h34, 1'b0);

    // reset in the middle of a wait
    en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h34;
    q3.push_back(m3[13]);
    #1 check("abort_stall_T", {31'd0, stall3}, 32'd1);
    @(negedge clk);
    rst3 = 1'b1;
    @(posedge clk); #1;
    check("abort_rdata", rdata3, 32'd0);
    check("abort_rerr", {31'd0, rerr3}, 32'd0);
    void'(q3.pop_front());
    exp_rd3 = 32'd0;
    @(negedge clk);
    rst3 = 1'b0; en3 = 1'b0;
    #1 check("abort_stall_idle", {31'd0, stall3}, 32'd0);
    @(posedge clk); #1;
    check("abort_idle_rdata", rdata3, 32'd0);
    @(negedge clk);
    read3("post_abort", 32'h10, 1'b0);

    check("q0_empty", q0.size(), 32'd0);
    check("q3_empty", q3.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data SRAM interface.
- Accepts en/wen/addr/wdata from the EX stage and returns data_sram_rdata to the MEM stage.
- Byte-lane writes complete in a single cycle.
- Reads have a fixed latency of 1+WAIT_CYCLES edges. When WAIT_CYCLES>0, stallreq drives the pipeline stall controller so the request is held stable.
- Serves as the data RAM model for simulation and as the template for the slow-memory port.

Parameters:
- ADDR_BITS, 10, word-index width; memory depth is 2**ADDR_BITS 32-bit words.
- WAIT_CYCLES, 0, extra read wait states (0..15); 0 gives classic 1-cycle synchronous read.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- data_sram_en  input  1  access request this cycle.
- data_sram_wen  input  4  byte write enables; nonzero = write, zero = read.
- data_sram_addr  input  32  byte address; bits [1:0] ignored.
- data_sram_wdata  input  32  write data, lane i = bits [8i+7:8i].
- data_sram_rdata  output  32  registered read data.
- stallreq  output  1  combinational; high = pipeline must hold the current request.
- range_err  output  1  registered 1-cycle pulse: access to out-of-range address.

Behaviour:
- Reset (rst=1 at edge): rdata=0, range_err=0, state=IDLE, wait counter=0. stallreq=0 while in IDLE with no read accepted. Memory contents are not cleared.
- Index: idx = addr[ADDR_BITS+1:2]. In range iff addr[31:ADDR_BITS+2]==0.
- States: IDLE, WAIT.
- IDLE, en=0: no action; rdata holds; range_err=0 next cycle.
- IDLE, en=1, wen!=0 (write):
  - At the edge, mem[idx] lane i <= wdata lane i for each wen[i]=1; other lanes unchanged.
  - rdata holds; stallreq=0; stay in IDLE.
  - Out of range: write dropped, range_err=1 next cycle.
- IDLE, en=1, wen=0 (read), WAIT_CYCLES=0:
  - At the edge, rdata <= mem[idx], or 0 if out of range (plus range_err=1).
  - rdata is valid in the following cycle; stallreq stays 0.
- IDLE, en=1, wen=0 (read), WAIT_CYCLES=N>0:
  - stallreq=1 combinationally in the accept cycle T.
  - At the edge: latch idx and range flag, counter <= N-1, go to WAIT.
- WAIT:
  - stallreq=1 while counter!=0.
  - When counter==0: stallreq=0, and at the edge rdata <= mem[latched idx] (or 0), range_err pulses if flagged, return to IDLE.
  - Otherwise counter decrements.
  - Net timing: stallreq high for exactly N cycles (T..T+N-1); rdata valid in cycle T+N+1.
  - Inputs are ignored in WAIT; the requester holds them stable under stall.
- Read-after-write: a write at edge E followed by a read of the same word accepted after E returns the new data (no forwarding hazard, since the write commits before the read samples).
- Partial-write merge uses the current memory contents; a byte not enabled is never modified.
- Reset during WAIT aborts the read: rdata=0, state=IDLE, no range_err pulse, memory unchanged.
- range_err is never asserted for en=0 cycles. It never stays high for 2 consecutive cycles unless consecutive out-of-range accesses occur.
- Back-to-back reads at WAIT_CYCLES=0: one read accepted every cycle; rdata updates every cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, en=0 → rdata=0, stallreq=0, range_err=0 every cycle.
- Full write/read, WAIT_CYCLES=0: write addr 0x10, wen=4'hF, wdata=0xDEADBEEF; next cycle read 0x10 → rdata=0xDEADBEEF in the cycle after the read, stallreq never 1.
- Byte lanes: mem[0x20]=0x11223344; write wen=4'b0101, wdata=0xAABBCCDD; read → 0x11BB33DD. Addr 0x23 aliases the same word.
- Wait states, WAIT_CYCLES=3: read 0x10 (holding 0x12345678) at cycle T → stallreq=1 in T, T+1, T+2 and 0 in T+3; rdata=0x12345678 from T+4; a changed addr during WAIT has no effect.
- Out of range, ADDR_BITS=10: read addr 0x00001000 → rdata=0, range_err=1 for exactly one cycle. Write to the same address → no memory change (a read of 0x0 is unaffected), range_err pulse.
- Reset mid-wait, WAIT_CYCLES=3: assert rst in cycle T+1 of a read → next cycle stallreq=0, rdata=0, state IDLE. A subsequent read behaves normally with a 3-cycle stall.
